// File: rtl/beamformer_core.sv
// beamformer_core: I2S receiver for NUM_MICS stereo mic pairs, per-stream
// programmable delay lines, delay-and-sum combiner and I2S left-slot serializer.
// Optional build macro BF_SATURATE_EN: clamp the raw sum to the sample range
// instead of returning the truncated average.
module beamformer_core #(
    parameter int NUM_MICS    = 4,
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32,
    parameter int DEPTH       = 16,
    localparam int S          = 2 * NUM_MICS,
    localparam int DW         = $clog2(DEPTH),
    // One spare code above S-1 so out-of-range selects are representable and ignored
    localparam int SELW       = $clog2(S + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MICS-1:0]    sd_in,
    output logic                   ws_out,
    input  logic                   cfg_we,
    input  logic [SELW-1:0]        cfg_sel,
    input  logic [DW-1:0]          cfg_data,
    output logic [SAMPLE_BITS-1:0] sum_out,
    output logic                   sum_valid,
    output logic                   sd_out
);

    localparam int FRAME_LEN = 2 * SLOT_BITS;
    localparam int CW        = $clog2(FRAME_LEN);
    localparam int LOGS      = $clog2(S);
    localparam int AW        = SAMPLE_BITS + LOGS + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_SLOT = CW'(SLOT_BITS);
    localparam logic [CW-1:0] CNT_SUM  = CW'(S);
    localparam logic [CW-1:0] CNT_L_LO = CW'(1);
    localparam logic [CW-1:0] CNT_L_HI = CW'(SAMPLE_BITS);
    localparam logic [CW-1:0] CNT_R_LO = CW'(SLOT_BITS + 1);
    localparam logic [CW-1:0] CNT_R_HI = CW'(SLOT_BITS + SAMPLE_BITS);
    localparam logic [DW-1:0] ONE_DW   = DW'(1);

    logic [CW-1:0]          cnt_reg;
    logic [DW-1:0]          wr_ptr_reg;
    logic                   primed_reg;
    logic signed [AW-1:0]   acc_reg;
    logic [SAMPLE_BITS-1:0] sum_reg;
    logic                   valid_reg;
    logic [SAMPLE_BITS-1:0] shift_reg;

    logic [SAMPLE_BITS-1:0] cap_w [S];
    logic [SAMPLE_BITS-1:0] rd_w  [S];

    // Frame phase decode
    logic frame_end_w, left_win_w, right_win_w, acc_win_w;
    assign frame_end_w = (cnt_reg == CNT_LAST);
    assign left_win_w  = (cnt_reg >= CNT_L_LO) && (cnt_reg <= CNT_L_HI);
    assign right_win_w = (cnt_reg >= CNT_R_LO) && (cnt_reg <= CNT_R_HI);
    assign acc_win_w   = (cnt_reg < CNT_SUM);
    assign ws_out      = (cnt_reg >= CNT_SLOT);

    // Frame counter and delay-line write pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            wr_ptr_reg <= '0;
            primed_reg <= 1'b0;
        end else if (frame_end_w) begin
            cnt_reg    <= '0;
            wr_ptr_reg <= wr_ptr_reg + ONE_DW;
            // From now on the buffers hold at least one complete frame
            primed_reg <= 1'b1;
        end else begin
            cnt_reg    <= cnt_reg + 1'b1;
        end
    end

    genvar gi;

    // Per-pair serial capture: even stream = left slot, odd stream = right slot
    generate
        for (gi = 0; gi < NUM_MICS; gi++) begin : g_pair
            logic [SAMPLE_BITS-1:0] left_reg;
            logic [SAMPLE_BITS-1:0] right_reg;

            // Shift the pair's data bit in MSB-first during its slot window
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    left_reg  <= '0;
                    right_reg <= '0;
                end else begin
                    if (left_win_w)
                        left_reg <= {left_reg[SAMPLE_BITS-2:0], sd_in[gi]};
                    if (right_win_w)
                        right_reg <= {right_reg[SAMPLE_BITS-2:0], sd_in[gi]};
                end
            end

            assign cap_w[2*gi]   = left_reg;
            assign cap_w[2*gi+1] = right_reg;
        end
    endgenerate

    // Per-stream delay registers and circular sample buffer
    generate
        for (gi = 0; gi < S; gi++) begin : g_stream
            logic [DW-1:0]          shadow_reg;
            logic [DW-1:0]          active_reg;
            logic [SAMPLE_BITS-1:0] line_mem [DEPTH];
            logic [DW-1:0]          rd_idx_w;

            // Shadow takes host writes; active is only refreshed at the frame boundary,
            // and the nonblocking copy naturally picks up the pre-write shadow value
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (frame_end_w)
                        active_reg <= shadow_reg;
                    if (cfg_we && (cfg_sel == SELW'(gi)))
                        shadow_reg <= cfg_data;
                end
            end

            // Buffer is cleared on reset so unwritten entries read back as zero
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++)
                        line_mem[i] <= '0;
                end else if (frame_end_w) begin
                    line_mem[wr_ptr_reg] <= cap_w[gi];
                end
            end

            // Newest entry sits at wr_ptr-1; DW-bit arithmetic wraps modulo DEPTH
            assign rd_idx_w   = wr_ptr_reg - ONE_DW - active_reg;
            assign rd_w[gi]   = line_mem[rd_idx_w];
        end
    endgenerate

    // Select the stream being accumulated this cycle and sign-extend it
    logic [LOGS-1:0]        stream_idx_w;
    logic [SAMPLE_BITS-1:0] rd_sample_w;
    logic signed [AW-1:0]   term_w;
    assign stream_idx_w = cnt_reg[LOGS-1:0];
    assign rd_sample_w  = rd_w[stream_idx_w];
    assign term_w       = {{(AW-SAMPLE_BITS){rd_sample_w[SAMPLE_BITS-1]}}, rd_sample_w};

    // Sequential accumulation, one stream per cycle, restarting at cnt 0
    always_ff @(posedge clk) begin
        if (!rst_n)
            acc_reg <= '0;
        else if (acc_win_w)
            acc_reg <= ((cnt_reg == '0) ? '0 : acc_reg) + term_w;
    end

    // Output scaling of the full-width sum
    logic [SAMPLE_BITS-1:0] scaled_w;
`ifdef BF_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX =
        {{(AW-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN =
        {{(AW-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};
    always_comb begin
        scaled_w = acc_reg[SAMPLE_BITS-1:0];
        if (acc_reg > SAT_MAX)
            scaled_w = SAT_MAX[SAMPLE_BITS-1:0];
        else if (acc_reg < SAT_MIN)
            scaled_w = SAT_MIN[SAMPLE_BITS-1:0];
    end
`else
    // Truncated average: divide by the stream count via arithmetic shift
    assign scaled_w = SAMPLE_BITS'(acc_reg >>> LOGS);
`endif

    // Publish the result once per frame, only after a full frame has been buffered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if ((cnt_reg == CNT_SUM) && primed_reg) begin
                sum_reg   <= scaled_w;
                valid_reg <= 1'b1;
            end
        end
    end

    assign sum_out   = sum_reg;
    assign sum_valid = valid_reg;

    // Serializer: load at frame start, shift out MSB-first in the left slot
    always_ff @(posedge clk) begin
        if (!rst_n)
            shift_reg <= '0;
        else if (cnt_reg == '0)
            shift_reg <= sum_reg;
        else if (left_win_w)
            shift_reg <= {shift_reg[SAMPLE_BITS-2:0], 1'b0};
    end

    assign sd_out = left_win_w ? shift_reg[SAMPLE_BITS-1] : 1'b0;

endmodule

// File: tb/tb_beamformer_core.sv
// tb_beamformer_core: directed bench for beamformer_core at default parameters.
// Drives I2S frames, keeps a frame-history model of the delay lines and
// checks ws_out, sum_valid, sum_out and sd_out every cycle via a scoreboard.
module tb_beamformer_core;

    localparam int NM    = 4;
    localparam int SB    = 16;
    localparam int SLOT  = 32;
    localparam int DEPTH = 16;
    localparam int S     = 8;
    localparam int LOGS  = 3;
    localparam int FRAME = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sd_in = '0;
    logic        ws_out;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_sel = '0;
    logic [3:0]  cfg_data = '0;
    logic [15:0] sum_out;
    logic        sum_valid;
    logic        sd_out;

    always #5 clk = ~clk;

    beamformer_core #(
        .NUM_MICS(NM), .SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sd_in(sd_in), .ws_out(ws_out),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .sum_out(sum_out), .sum_valid(sum_valid), .sd_out(sd_out)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          frame_idx = 0;
    int          cyc = 0;
    logic [15:0] hist [0:S-1][0:255];
    logic [15:0] cur_samp [0:S-1];
    int          shadow_m [0:S-1];
    int          active_m [0:S-1];
    logic [15:0] exp_q [$];
    logic [15:0] exp_sum_out = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s frame=%0d cnt=%0d observed=%0h expected=%0h",
                   tag, frame_idx, cyc, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] scale(input int sum);
        int t;
`ifdef BF_SATURATE_EN
        if (sum > 32767)  return 16'h7FFF;
        if (sum < -32768) return 16'h8000;
        t = sum;
`else
        t = sum >>> LOGS;
`endif
        return t[15:0];
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        cfg_we = 1'b0;
        sd_in  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc = -1;
            chk("rst_ws_out", 32'(ws_out), 32'd0);
            chk("rst_sum_valid", 32'(sum_valid), 32'd0);
            chk("rst_sum_out", 32'(sum_out), 32'd0);
            chk("rst_sd_out", 32'(sd_out), 32'd0);
        end
        rst_n = 1'b1;
        frame_idx   = 0;
        exp_sum_out = '0;
        exp_q.delete();
        for (int s = 0; s < S; s++) begin
            shadow_m[s] = 0;
            active_m[s] = 0;
        end
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int s = 0; s < S; s++) cur_samp[s] = v;
    endtask

    task automatic set_rand();
        for (int s = 0; s < S; s++) cur_samp[s] = 16'($urandom);
    endtask

    // One 64-cycle frame; entered and left at the negedge of a cnt=0 cycle.
    task automatic run_frame(input int cfg_c, input int sel, input int data, input int rst_at);
        int          sum;
        int          j;
        logic [15:0] sd_word;
        logic        exp_v;
        logic        exp_sd;
        if (frame_idx >= 1) begin
            sum = 0;
            for (int s = 0; s < S; s++) begin
                j = frame_idx - 1 - active_m[s];
                if (j >= 0) sum += int'($signed(hist[s][j]));
            end
            exp_q.push_back(scale(sum));
        end
        for (int s = 0; s < S; s++) hist[s][frame_idx] = cur_samp[s];
        sd_word = exp_sum_out;
        for (int c = 0; c < FRAME; c++) begin
            cyc   = c;
            exp_v = (frame_idx >= 1) && (c == S + 1);
            if (exp_v) begin
                if (exp_q.size() > 0) exp_sum_out = exp_q.pop_front();
                $display("txn frame=%0d sum_valid=%0b sum_out=%h expected=%h",
                         frame_idx, sum_valid, sum_out, exp_sum_out);
            end
            exp_sd = 1'b0;
            if (c >= 1 && c <= SB) exp_sd = sd_word[SB-c];
            chk("ws_out", 32'(ws_out), 32'(c >= SLOT));
            chk("sum_valid", 32'(sum_valid), 32'(exp_v));
            chk("sum_out", 32'(sum_out), 32'(exp_sum_out));
            chk("sd_out", 32'(sd_out), 32'(exp_sd));
            if (c == rst_at) begin
                do_reset();
                return;
            end
            for (int k = 0; k < NM; k++) begin
                if (c >= 1 && c <= SB)
                    sd_in[k] = cur_samp[2*k][SB-c];
                else if (c >= SLOT + 1 && c <= SLOT + SB)
                    sd_in[k] = cur_samp[2*k+1][SLOT+SB-c];
                else
                    sd_in[k] = 1'($urandom);
            end
            cfg_we   = (c == cfg_c);
            cfg_sel  = 4'(sel);
            cfg_data = 4'(data);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        if (cfg_c >= 0 && cfg_c != FRAME - 1 && sel < S) shadow_m[sel] = data;
        for (int s = 0; s < S; s++) active_m[s] = shadow_m[s];
        if (cfg_c == FRAME - 1 && sel < S) shadow_m[sel] = data;
        frame_idx++;
    endtask

    initial begin
        do_reset();
        // Uniform 0x0100 on every stream, all delays zero
        set_all(16'h0100);
        repeat (4) run_frame(-1, 0, 0, -1);
        // Large positive and negative full-scale sums
        set_all(16'h7000);
        repeat (2) run_frame(-1, 0, 0, -1);
        set_all(16'h9000);
        repeat (2) run_frame(-1, 0, 0, -1);
        // Mixed data with mid-frame delay updates
        for (int i = 0; i < 6; i++) begin
            set_rand();
            run_frame(20, i, (i * 5 + 3) % 16, -1);
        end
        // Impulse on stream 0 with delay 3, all other delays zero
        for (int s = 0; s < S; s++) begin
            set_all(16'h0000);
            run_frame(10, s, (s == 0) ? 3 : 0, -1);
        end
        set_all(16'h0000);
        cur_samp[0] = 16'h0100;
        run_frame(-1, 0, 0, -1);
        set_all(16'h0000);
        repeat (6) run_frame(-1, 0, 0, -1);
        // Maximum delay on stream 1 across several pointer wraps
        set_rand();
        run_frame(5, 1, 15, -1);
        repeat (20) begin
            set_rand();
            run_frame(-1, 0, 0, -1);
        end
        // Delay write on the copy cycle, then an out-of-range select
        set_rand();
        run_frame(FRAME - 1, 2, 7, -1);
        repeat (3) begin
            set_rand();
            run_frame(-1, 0, 0, -1);
        end
        set_rand();
        run_frame(30, 9, 5, -1);
        repeat (3) begin
            set_rand();
            run_frame(-1, 0, 0, -1);
        end
        // Reset in the middle of accumulation, then recovery
        set_rand();
        run_frame(-1, 0, 0, 3);
        repeat (3) begin
            set_rand();
            run_frame(-1, 0, 0, -1);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
